// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the FP multiplier post-multiply path.
// Holds the rounding-mode encodings and the FSM state type.
package fpu_mult_pkg;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RPI = 2'b10;
  localparam logic [1:0] RM_RMI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/sgf_round_inc.sv
// Round-increment decision plus the (MW+1)-bit increment of the normalized fraction.
// Purely combinational; carry_o flags a round carry into the exponent.
module sgf_round_inc
  import fpu_mult_pkg::*;
#(
  parameter int MW = 52
) (
  input  logic [MW-1:0] frac_i,
  input  logic          g_i,
  input  logic          r_i,
  input  logic          s_i,
  input  logic          sign_i,
  input  logic [1:0]    rm_i,
  output logic [MW-1:0] frac_o,
  output logic          carry_o,
  output logic          inexact_o
);
  logic          inc;
  logic          lost;
  logic [MW:0]   sum;

  assign lost = g_i | r_i | s_i;

  always_comb begin
    inc = 1'b0;
    case (rm_i)
      RM_RNE: inc = g_i & (r_i | s_i | frac_i[0]);
      RM_RZ:  inc = 1'b0;
      RM_RPI: inc = ~sign_i & lost;
      RM_RMI: inc = sign_i & lost;
      default: inc = 1'b0;
    endcase
  end

  assign sum       = {1'b0, frac_i} + {{MW{1'b0}}, inc};
  assign carry_o   = sum[MW];
  // On carry the significand becomes 10.000..., so the fraction field is zero.
  assign frac_o    = sum[MW] ? '0 : sum[MW-1:0];
  assign inexact_o = lost;
endmodule

// File: rtl/sgf_mult_norm_round.sv
// Post-multiply normalize/round stage: IDLE -> NORM -> ROUND -> DONE over start/valid/ack.
// Define SGF_ROUND_MODES_EN for all four rounding modes; otherwise RNE only and rm_i is ignored.
module sgf_mult_norm_round
  import fpu_mult_pkg::*;
#(
  parameter int SW = 54,
  parameter int MW = 52
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2*SW-1:0] sgf_product_i,
  input  logic            sign_i,
  input  logic [1:0]      rm_i,
  input  logic            ack_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [MW-1:0]   frac_o,
  output logic [1:0]      exp_adj_o,
  output logic            inexact_o
);
  state_e            state_q, state_d;
  logic [2*MW+1:0]   prod_q, prod_d;
  logic              sign_q, sign_d;
  logic [MW-1:0]     nfrac_q, nfrac_d;
  logic [2:0]        grs_q, grs_d;
  logic              ovf_q, ovf_d;
  logic [MW-1:0]     frac_q, frac_d;
  logic [1:0]        adj_q, adj_d;
  logic              inexact_q, inexact_d;
  logic              valid_q, valid_d;
  logic [1:0]        rm_eff;

`ifdef SGF_ROUND_MODES_EN
  logic [1:0]        rm_q, rm_d;
  assign rm_eff = rm_q;
`else
  logic              rm_unused;
  assign rm_unused = ^rm_i;
  assign rm_eff    = RM_RNE;
`endif

  // Normalization: a product in [2,4) is shifted right once; the shifted-out
  // bit still contributes to sticky.
  logic              ovf;
  logic [2*MW-1:0]   shifted;
  assign ovf     = prod_q[2*MW+1];
  assign shifted = ovf ? prod_q[2*MW:1] : prod_q[2*MW-1:0];

  logic [MW-1:0]     rnd_frac;
  logic              rnd_carry;
  logic              rnd_inexact;

  sgf_round_inc #(.MW(MW)) u_round_inc (
    .frac_i    (nfrac_q),
    .g_i       (grs_q[2]),
    .r_i       (grs_q[1]),
    .s_i       (grs_q[0]),
    .sign_i    (sign_q),
    .rm_i      (rm_eff),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    sign_d    = sign_q;
    nfrac_d   = nfrac_q;
    grs_d     = grs_q;
    ovf_d     = ovf_q;
    frac_d    = frac_q;
    adj_d     = adj_q;
    inexact_d = inexact_q;
    valid_d   = valid_q;
`ifdef SGF_ROUND_MODES_EN
    rm_d      = rm_q;
`endif
    case (state_q)
      ST_IDLE: if (start_i) begin
        prod_d  = sgf_product_i[2*MW+1:0];
        sign_d  = sign_i;
`ifdef SGF_ROUND_MODES_EN
        rm_d    = rm_i;
`endif
        state_d = ST_NORM;
      end
      ST_NORM: begin
        nfrac_d = shifted[2*MW-1:MW];
        grs_d   = {shifted[MW-1], shifted[MW-2],
                   (|shifted[MW-3:0]) | (ovf & prod_q[0])};
        ovf_d   = ovf;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        frac_d    = rnd_frac;
        adj_d     = {1'b0, ovf_q} + {1'b0, rnd_carry};
        inexact_d = rnd_inexact;
        valid_d   = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: if (ack_i) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prod_q    <= '0;
      sign_q    <= 1'b0;
      nfrac_q   <= '0;
      grs_q     <= '0;
      ovf_q     <= 1'b0;
      frac_q    <= '0;
      adj_q     <= '0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef SGF_ROUND_MODES_EN
      rm_q      <= RM_RNE;
`endif
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      sign_q    <= sign_d;
      nfrac_q   <= nfrac_d;
      grs_q     <= grs_d;
      ovf_q     <= ovf_d;
      frac_q    <= frac_d;
      adj_q     <= adj_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
`ifdef SGF_ROUND_MODES_EN
      rm_q      <= rm_d;
`endif
    end
  end

  // Upper product bits are zero by contract; flag a violation in simulation.
  always_ff @(posedge clk) begin
    if (!rst && start_i && (state_q == ST_IDLE))
      assert ((sgf_product_i >> (2*MW+2)) == '0)
        else $error("sgf_mult_norm_round: upper product bits nonzero");
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign valid_o   = valid_q;
  assign frac_o    = frac_q;
  assign exp_adj_o = adj_q;
  assign inexact_o = inexact_q;
endmodule

// File: tb/tb_sgf_mult_norm_round.sv
// Self-checking bench for sgf_mult_norm_round: directed corner cases plus random
// 53x53-bit significand products against an arithmetic rounding model.
module tb_sgf_mult_norm_round;
  localparam int SW = 54;
  localparam int MW = 52;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2*SW-1:0] sgf_product_i;
  logic            sign_i;
  logic [1:0]      rm_i;
  logic            ack_i;
  logic            ready_o;
  logic            valid_o;
  logic [MW-1:0]   frac_o;
  logic [1:0]      exp_adj_o;
  logic            inexact_o;

  int n_cmp = 0;
  int n_bad = 0;

  sgf_mult_norm_round #(.SW(SW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sgf_product_i(sgf_product_i),
    .sign_i(sign_i), .rm_i(rm_i), .ack_i(ack_i), .ready_o(ready_o),
    .valid_o(valid_o), .frac_o(frac_o), .exp_adj_o(exp_adj_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Reference: value = P / 2^shift with the remainder judged against half an ulp.
  function automatic void model(input logic [2*SW-1:0] p, input logic s, input logic [1:0] rm_in,
                                output logic [MW-1:0] f, output logic [1:0] a, output logic ix);
    logic [127:0] pp, q, rem, half;
    int           sh;
    logic         inc;
    logic [1:0]   rm;
    rm = rm_in;
`ifndef SGF_ROUND_MODES_EN
    rm = 2'b00;
`endif
    pp   = 128'(p);
    sh   = pp[2*MW+1] ? MW + 1 : MW;
    q    = pp >> sh;
    rem  = pp - (q << sh);
    half = 128'd1 << (sh - 1);
    case (rm)
      2'b00:   inc = (rem > half) || ((rem == half) && q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = !s && (rem != 0);
      default: inc = s && (rem != 0);
    endcase
    q  = q + 128'(inc);
    a  = 2'(sh == MW + 1) + 2'(q >= (128'd1 << (MW + 1)));
    f  = q[MW-1:0];
    ix = (rem != 0);
  endfunction

  logic [MW-1:0] ef;
  logic [1:0]    ea;
  logic          ei;

  // Issue one operation and stop in DONE with outputs checked against the model.
  task automatic do_op(input string tag, input logic [2*SW-1:0] p, input logic s,
                       input logic [1:0] rm, input logic poke_start);
    model(p, s, rm, ef, ea, ei);
    check({tag, ".ready"}, 64'(ready_o), 64'd1);
    start_i = 1'b1; sgf_product_i = p; sign_i = s; rm_i = rm;
    tick();
    start_i = 1'b0; sgf_product_i = '0;
    check({tag, ".v1"}, 64'(valid_o), 64'd0);
    if (poke_start) begin
      start_i = 1'b1; sgf_product_i = 108'd3 << 104; sign_i = ~s; ack_i = 1'b1;
    end
    tick();
    start_i = 1'b0; sgf_product_i = '0; sign_i = s; ack_i = 1'b0;
    check({tag, ".v2"}, 64'(valid_o), 64'd0);
    tick();
    check({tag, ".v3"}, 64'(valid_o), 64'd1);
    check({tag, ".frac"}, 64'(frac_o), 64'(ef));
    check({tag, ".adj"}, 64'(exp_adj_o), 64'(ea));
    check({tag, ".inx"}, 64'(inexact_o), 64'(ei));
  endtask

  task automatic do_ack(input string tag);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check({tag, ".ackv"}, 64'(valid_o), 64'd0);
    check({tag, ".ackr"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    logic [2*SW-1:0] p;
    logic [MW:0]     sa, sb;
    logic [MW-1:0]   hf;

    rst = 1'b1; start_i = 1'b0; sgf_product_i = '0; sign_i = 1'b0; rm_i = 2'b00; ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst.ready", 64'(ready_o), 64'd1);
    check("rst.valid", 64'(valid_o), 64'd0);
    check("rst.frac",  64'(frac_o), 64'd0);
    check("rst.adj",   64'(exp_adj_o), 64'd0);
    check("rst.inx",   64'(inexact_o), 64'd0);

    do_op("one", 108'd1 << 104, 1'b0, 2'b00, 1'b0);
    check("one.fc", 64'(frac_o), 64'd0);
    check("one.ac", 64'(exp_adj_o), 64'd0);
    check("one.ic", 64'(inexact_o), 64'd0);
    do_ack("one");

    do_op("onefive", 108'd9 << 102, 1'b0, 2'b00, 1'b0);
    check("onefive.fc", 64'(frac_o), 64'd1 << 49);
    check("onefive.ac", 64'(exp_adj_o), 64'd1);
    check("onefive.ic", 64'(inexact_o), 64'd0);
    do_ack("onefive");

    do_op("carry", (108'd1 << 105) - 108'd1, 1'b0, 2'b00, 1'b0);
    check("carry.fc", 64'(frac_o), 64'd0);
    check("carry.ac", 64'(exp_adj_o), 64'd1);
    check("carry.ic", 64'(inexact_o), 64'd1);
    do_ack("carry");

    p = (108'd1 << 104) | (108'd1 << 51);
    do_op("tie_rne", p, 1'b0, 2'b00, 1'b0);
    check("tie_rne.fc", 64'(frac_o), 64'd0);
    check("tie_rne.ic", 64'(inexact_o), 64'd1);
    do_ack("tie_rne");
    do_op("tie_rpi", p, 1'b0, 2'b10, 1'b0);
`ifdef SGF_ROUND_MODES_EN
    check("tie_rpi.fc", 64'(frac_o), 64'd1);
`endif
    do_ack("tie_rpi");
    do_op("tie_rmi", p, 1'b0, 2'b11, 1'b0);
    check("tie_rmi.fc", 64'(frac_o), 64'd0);
    do_ack("tie_rmi");

    p = 108'((1 << 53) - 1) * 108'((1 << 53) - 1);
    do_op("max_rz", p, 1'b0, 2'b01, 1'b0);
`ifdef SGF_ROUND_MODES_EN
    check("max_rz.fc", 64'(frac_o), 64'hF_FFFF_FFFF_FFFE);
    check("max_rz.ac", 64'(exp_adj_o), 64'd1);
    check("max_rz.ic", 64'(inexact_o), 64'd1);
`endif
    do_ack("max_rz");
    do_op("max_rpi", p, 1'b0, 2'b10, 1'b0);
`ifdef SGF_ROUND_MODES_EN
    check("max_rpi.fc", 64'(frac_o), 64'hF_FFFF_FFFF_FFFF);
`endif
    do_ack("max_rpi");

    do_op("zero", '0, 1'b1, 2'b10, 1'b0);
    check("zero.fc", 64'(frac_o), 64'd0);
    check("zero.ac", 64'(exp_adj_o), 64'd0);
    check("zero.ic", 64'(inexact_o), 64'd0);
    do_ack("zero");

    // Stall in DONE, with start/ack pokes during NORM/ROUND that must be ignored.
    do_op("hold", 108'd9 << 102 | 108'd12345, 1'b1, 2'b11, 1'b1);
    hf = frac_o;
    repeat (5) begin
      tick();
      check("hold.v", 64'(valid_o), 64'd1);
      check("hold.f", 64'(frac_o), 64'(ef));
    end
    do_ack("hold");

    // Reset while in ROUND aborts the operation.
    start_i = 1'b1; sgf_product_i = (108'd1 << 105) - 108'd1;
    tick();
    start_i = 1'b0; sgf_product_i = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.ready", 64'(ready_o), 64'd1);
    check("abort.valid", 64'(valid_o), 64'd0);
    tick();
    check("abort.stay", 64'(valid_o), 64'd0);

    for (int i = 0; i < 40; i++) begin
      sa = {1'b1, 52'({$urandom, $urandom})};
      sb = {1'b1, 52'({$urandom, $urandom})};
      if (i % 8 == 0) sb = {1'b1, 52'd0};
      p = 108'(sa) * 108'(sb);
      do_op($sformatf("rnd%0d", i), p, 1'($urandom), 2'($urandom), 1'(i % 5 == 0));
      do_ack($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
